// File: rtl/ofdm_pkg.sv
// Shared types and helpers for the OFDM symbol scheduler.
// Slot classes, FSM states, default geometry and a saturating negate.
package ofdm_pkg;

    localparam int unsigned DEF_W             = 16;
    localparam int unsigned DEF_N_SC          = 64;
    localparam int unsigned DEF_PILOT_SPACING = 8;
    localparam int unsigned MAX_W             = 32;

    typedef enum logic [1:0] {SLOT_NULL, SLOT_PILOT, SLOT_DATA} slot_class_e;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    // Two's complement negate of the low w bits; the most negative value maps to the most positive.
    function automatic logic [MAX_W-1:0] sat_negate(input logic [MAX_W-1:0] v,
                                                    input int unsigned      w);
        logic [MAX_W-1:0] mask;
        logic [MAX_W-1:0] min_neg;
        mask    = {MAX_W{1'b1}} >> (MAX_W - w);
        min_neg = MAX_W'(1) << (w - 1);
        if ((v & mask) == min_neg) begin
            return min_neg - MAX_W'(1);
        end
        return (~v + MAX_W'(1)) & mask;
    endfunction

endpackage

// File: rtl/ofdm_slot_classifier.sv
// Maps a subcarrier index to its slot class: null at DC, pilots mid-period, data elsewhere.
module ofdm_slot_classifier
    import ofdm_pkg::*;
#(
    parameter int unsigned N_SC          = DEF_N_SC,
    parameter int unsigned PILOT_SPACING = DEF_PILOT_SPACING
) (
    input  logic [$clog2(N_SC)-1:0] idx,
    output slot_class_e             cls
);

    localparam int unsigned PHASE_W = $clog2(PILOT_SPACING);

    logic [PHASE_W-1:0] phase;

    // Spacing is a power of two, so the modulo is just the low index bits.
    assign phase = idx[PHASE_W-1:0];

    always_comb begin
        cls = SLOT_DATA;
        if (idx == '0) begin
            cls = SLOT_NULL;
        end else if (phase == PHASE_W'(PILOT_SPACING / 2)) begin
            cls = SLOT_PILOT;
        end
    end

endmodule

// File: rtl/ofdm_symbol_scheduler.sv
// Emits a burst of frequency-domain OFDM symbols as a stream of null, pilot and data slots,
// pulling data samples from upstream and flipping pilot polarity every symbol.
module ofdm_symbol_scheduler
    import ofdm_pkg::*;
#(
    parameter int unsigned N_SC          = DEF_N_SC,
    parameter int unsigned PILOT_SPACING = DEF_PILOT_SPACING,
    parameter int unsigned W             = DEF_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [7:0]              num_symbols,
    input  logic [W-1:0]            pilot_i,
    input  logic [W-1:0]            pilot_q,
    input  logic                    data_valid,
    output logic                    data_ready,
    input  logic [W-1:0]            data_i,
    input  logic [W-1:0]            data_q,
    output logic                    sc_valid,
    input  logic                    sc_ready,
    output logic [W-1:0]            sc_i,
    output logic [W-1:0]            sc_q,
    output logic [$clog2(N_SC)-1:0] sc_index,
    output logic                    sc_last,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned    IDX_W = $clog2(N_SC);
    localparam logic [IDX_W-1:0] K_MAX = IDX_W'(N_SC - 1);

    state_e           state;
    logic [IDX_W-1:0] k;
    logic [7:0]       sym;
    logic [7:0]       num_sym;
    logic [W-1:0]     pil_i;
    logic [W-1:0]     pil_q;
    logic             remain;

    slot_class_e      cls;
    logic             out_free;
    logic             load;
    logic             last_slot;
    logic [W-1:0]     pilot_out_i;
    logic [W-1:0]     pilot_out_q;

    ofdm_slot_classifier #(
        .N_SC          (N_SC),
        .PILOT_SPACING (PILOT_SPACING)
    ) u_classifier (
        .idx (k),
        .cls (cls)
    );

    // k/sym track the next slot to load; remain clears once the final slot is loaded.
    assign out_free   = !sc_valid || sc_ready;
    assign data_ready = (state == StRun) && remain && out_free && (cls == SLOT_DATA);
    assign load       = (state == StRun) && remain && out_free &&
                        ((cls != SLOT_DATA) || data_valid);
    assign last_slot  = (k == K_MAX) && (sym == num_sym - 8'd1);

    assign pilot_out_i = sym[0] ? W'(sat_negate(MAX_W'(pil_i), W)) : pil_i;
    assign pilot_out_q = sym[0] ? W'(sat_negate(MAX_W'(pil_q), W)) : pil_q;

    assign busy = (state == StRun);
    assign done = (state == StDone);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= StIdle;
            k        <= '0;
            sym      <= '0;
            num_sym  <= '0;
            pil_i    <= '0;
            pil_q    <= '0;
            remain   <= 1'b0;
            sc_valid <= 1'b0;
            sc_i     <= '0;
            sc_q     <= '0;
            sc_index <= '0;
            sc_last  <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (start) begin
                        num_sym <= num_symbols;
                        pil_i   <= pilot_i;
                        pil_q   <= pilot_q;
                        k       <= '0;
                        sym     <= '0;
                        if (num_symbols != 8'd0) begin
                            remain <= 1'b1;
                            state  <= StRun;
                        end else begin
                            state  <= StDone;
                        end
                    end
                end
                StRun: begin
                    if (load) begin
                        sc_valid <= 1'b1;
                        sc_index <= k;
                        sc_last  <= (k == K_MAX);
                        case (cls)
                            SLOT_NULL: begin
                                sc_i <= '0;
                                sc_q <= '0;
                            end
                            SLOT_PILOT: begin
                                sc_i <= pilot_out_i;
                                sc_q <= pilot_out_q;
                            end
                            default: begin
                                sc_i <= data_i;
                                sc_q <= data_q;
                            end
                        endcase
                        k <= k + 1'b1;
                        if (k == K_MAX) begin
                            sym <= sym + 8'd1;
                        end
                        if (last_slot) begin
                            remain <= 1'b0;
                        end
                    end else if (sc_ready) begin
                        sc_valid <= 1'b0;
                    end
                    if (!remain && sc_valid && sc_ready) begin
                        state <= StDone;
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ofdm_symbol_scheduler.sv
// Directed bench for ofdm_symbol_scheduler: burst content, pilot polarity, stalls,
// zero-length bursts, ignored mid-burst start and mid-burst reset.
module tb_ofdm_symbol_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  num_symbols;
    logic [15:0] pilot_i;
    logic [15:0] pilot_q;
    logic        data_valid;
    logic        data_ready;
    logic [15:0] data_i;
    logic [15:0] data_q;
    logic        sc_valid;
    logic        sc_ready;
    logic [15:0] sc_i;
    logic [15:0] sc_q;
    logic [5:0]  sc_index;
    logic        sc_last;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;

    ofdm_symbol_scheduler #(
        .N_SC          (64),
        .PILOT_SPACING (8),
        .W             (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .num_symbols (num_symbols),
        .pilot_i     (pilot_i),
        .pilot_q     (pilot_q),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .data_i      (data_i),
        .data_q      (data_q),
        .sc_valid    (sc_valid),
        .sc_ready    (sc_ready),
        .sc_i        (sc_i),
        .sc_q        (sc_q),
        .sc_index    (sc_index),
        .sc_last     (sc_last),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_data(input int k);
        return (k != 0) && ((k % 8) != 4);
    endfunction

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_sc_valid"}, 32'(sc_valid), 0);
        check_eq({tag, "_sc_i"}, 32'(sc_i), 0);
        check_eq({tag, "_sc_q"}, 32'(sc_q), 0);
        check_eq({tag, "_sc_index"}, 32'(sc_index), 0);
        check_eq({tag, "_sc_last"}, 32'(sc_last), 0);
        check_eq({tag, "_data_ready"}, 32'(data_ready), 0);
        check_eq({tag, "_busy"}, 32'(busy), 0);
        check_eq({tag, "_done"}, 32'(done), 0);
    endtask

    // Entered and left at 1 time unit after a rising edge; p1i/p1q are odd-symbol pilots.
    task automatic run_burst(input int num, input logic [15:0] pi, input logic [15:0] pq,
                             input logic [15:0] p1i, input logic [15:0] p1q,
                             input bit stall, input bit poke, input bit abort);
        int          cyc, exp_k, exp_sym, seen, first_v, last_hs, rem, nl, total, limit;
        bit          hold, pend, finished, exp_dr;
        logic [15:0] sup, exp_d, pend_val, ei, eq;
        logic [15:0] h_i, h_q;
        logic [5:0]  h_idx;
        logic        h_last;

        start       = 1'b1;
        num_symbols = num[7:0];
        pilot_i     = pi;
        pilot_q     = pq;
        sc_ready    = 1'b1;
        data_valid  = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (num == 0) begin
            check_eq("zero_done", 32'(done), 1);
            check_eq("zero_busy", 32'(busy), 0);
            check_eq("zero_valid", 32'(sc_valid), 0);
            @(posedge clk);
            #1;
            check_eq("zero_done_one_cycle", 32'(done), 0);
            check_eq("zero_valid_after", 32'(sc_valid), 0);
            return;
        end
        check_eq("busy_after_start", 32'(busy), 1);
        check_eq("valid_after_start", 32'(sc_valid), 0);

        total = 64 * num;
        limit = total * 8 + 50;
        cyc = 0; exp_k = 0; exp_sym = 0; seen = 0; first_v = -1; last_hs = -1;
        hold = 0; pend = 0; finished = 0;
        sup = 16'd1; exp_d = 16'd1;
        h_i = '0; h_q = '0; h_idx = '0; h_last = 1'b0; pend_val = '0;

        while (cyc < limit) begin
            if (abort && sc_valid && sc_index == 6'd30) begin
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
                check_idle_outputs("abort");
                for (int i = 0; i < 3; i++) begin
                    @(posedge clk);
                    #1;
                    check_eq("abort_no_done", 32'(done), 0);
                    check_eq("abort_no_valid", 32'(sc_valid), 0);
                end
                return;
            end
            if (pend) begin
                check_eq("load_after_accept", {15'd0, sc_valid, sc_i}, {15'd0, 1'b1, pend_val});
                pend = 0;
            end
            if (hold) begin
                check_eq("stall_stable", {9'd0, sc_valid, sc_i, sc_index},
                         {9'd0, 1'b1, h_i, h_idx});
                check_eq("stall_stable_q", {15'd0, sc_last, sc_q}, {15'd0, h_last, h_q});
            end
            if (done) begin
                check_eq("done_after_last_hs", 32'(cyc - last_hs), 1);
                check_eq("done_busy_low", 32'(busy), 0);
                check_eq("done_valid_low", 32'(sc_valid), 0);
                finished = 1;
                break;
            end
            sc_ready   = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            data_valid = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            data_i     = sup;
            data_q     = sup + 16'h1000;
            if (poke && (cyc == 20 || cyc == 21)) begin
                start       = 1'b1;
                num_symbols = 8'd5;
            end else begin
                start = 1'b0;
            end
            #1;
            rem    = total - seen - (sc_valid ? 1 : 0);
            nl     = sc_valid ? (exp_k + 1) % 64 : exp_k;
            exp_dr = (rem > 0) && is_data(nl) && (!sc_valid || sc_ready);
            check_eq("data_ready", 32'(data_ready), 32'(exp_dr));
            if (data_ready && data_valid) begin
                pend     = 1;
                pend_val = sup;
                sup      = sup + 16'd1;
            end
            if (sc_valid && first_v < 0) first_v = cyc;
            if (sc_valid && sc_ready) begin
                if (exp_k == 0) begin
                    ei = 16'h0000; eq = 16'h0000;
                end else if (exp_k % 8 == 4) begin
                    ei = exp_sym[0] ? p1i : pi;
                    eq = exp_sym[0] ? p1q : pq;
                end else begin
                    ei = exp_d; eq = exp_d + 16'h1000;
                    exp_d = exp_d + 16'd1;
                end
                check_eq("slot_index", 32'(sc_index), 32'(exp_k));
                check_eq("slot_i", 32'(sc_i), 32'(ei));
                check_eq("slot_q", 32'(sc_q), 32'(eq));
                check_eq("slot_last", 32'(sc_last), 32'(exp_k == 63));
                seen++;
                last_hs = cyc;
                exp_k = (exp_k + 1) % 64;
                if (exp_k == 0) exp_sym++;
            end
            hold   = sc_valid && !sc_ready;
            h_i    = sc_i;
            h_q    = sc_q;
            h_idx  = sc_index;
            h_last = sc_last;
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b0;
        check_eq("burst_timeout", 32'(finished), 1);
        check_eq("slots_total", 32'(seen), 32'(total));
        check_eq("data_count", 32'(exp_d - 16'd1), 32'(55 * num));
        check_eq("no_extra_consume", 32'(sup), 32'(exp_d));
        check_eq("first_valid_latency", 32'(first_v), 1);
        if (!stall) check_eq("throughput", 32'(cyc - first_v), 32'(total));
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        num_symbols = 8'd0;
        pilot_i     = '0;
        pilot_q     = '0;
        data_valid  = 1'b0;
        data_i      = '0;
        data_q      = '0;
        sc_ready    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_burst(1, 16'h0014, 16'h0028, 16'hFFEC, 16'hFFD8, 1'b0, 1'b0, 1'b0);
        run_burst(2, 16'h0014, 16'h0028, 16'hFFEC, 16'hFFD8, 1'b0, 1'b0, 1'b0);
        run_burst(2, 16'h8000, 16'h7FFF, 16'h7FFF, 16'h8001, 1'b1, 1'b0, 1'b0);
        run_burst(0, 16'h0014, 16'h0028, 16'hFFEC, 16'hFFD8, 1'b0, 1'b0, 1'b0);
        run_burst(1, 16'h0014, 16'h0028, 16'hFFEC, 16'hFFD8, 1'b0, 1'b1, 1'b0);
        run_burst(1, 16'h0014, 16'h0028, 16'hFFEC, 16'hFFD8, 1'b0, 1'b0, 1'b1);
        run_burst(1, 16'h0014, 16'h0028, 16'hFFEC, 16'hFFD8, 1'b1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ofdm_symbol_scheduler.md
# ofdm_symbol_scheduler

Sequences a frequency-domain OFDM symbol for the I/Q datapath: for each of N_SC subcarrier slots it emits either a null, a pilot, or the next user data sample, in index order, over a valid/ready stream. Sits between the QAM mapper's I/Q sample stream and the symbol replication/IFFT stage. It runs a programmed burst of symbols per start command and alternates pilot polarity per symbol.

## Interface
- N_SC, 64: subcarriers per symbol; power of two, 8..256
- PILOT_SPACING, 8: pilot period in subcarriers; power of two, divides N_SC
- W, 16: I/Q sample width, two's complement
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle command; accepted only in IDLE
- num_symbols  in  8  symbols in burst, sampled on accepted start
- pilot_i, pilot_q  in  W each  base pilot value, sampled on accepted start
- data_valid  in  1  upstream sample available
- data_ready  out  1  scheduler consumes a sample this cycle
- data_i, data_q  in  W each  upstream sample
- sc_valid  out  1  output slot valid
- sc_ready  in  1  downstream accepts
- sc_i, sc_q  out  W each  slot value
- sc_index  out  log2(N_SC)  subcarrier index of current slot
- sc_last  out  1  slot is index N_SC-1
- busy  out  1  state is RUN
- done  out  1  one-cycle pulse at burst end

## Operation
- Slot class by index k: k==0 → null (0,0); k % PILOT_SPACING == PILOT_SPACING/2 → pilot; else data. Defaults: pilots at 4,12,…,60; 55 data slots.
- Pilot value: (pilot_i, pilot_q) on even symbol count, negated on odd. Negation saturates: −2^(W−1) → 2^(W−1)−1.
- States: IDLE, RUN, DONE.
  - IDLE: start && num_symbols≠0 → RUN, latch config, k=0, sym=0. start && num_symbols==0 → DONE.
  - RUN: a slot completes when sc_valid && sc_ready. After slot k=N_SC−1 of symbol num_symbols−1 completes → DONE. Otherwise k wraps to 0 and sym increments.
  - DONE: done=1 for one cycle → IDLE.
- start in RUN/DONE is ignored; the latched config cannot change mid-burst.
- Output register: loads a new slot when (!sc_valid || sc_ready) in RUN and slots remain. Null/pilot slots load unconditionally; data slots load only when data_valid.
- data_ready = RUN && current slot is data && (!sc_valid || sc_ready) && slots remain. Combinational from state/registers and sc_ready; never depends on data_valid.
- sc_valid, once high, holds with stable sc_i/sc_q/sc_index/sc_last until sc_ready.
- Upstream stall on a data slot produces a bubble (sc_valid low); the scheduler never skips or reorders slots.

## Timing
- Reset values: sc_valid=0, sc_i=sc_q=0, sc_index=0, sc_last=0, data_ready=0, busy=0, done=0, state IDLE, counters 0.
- rst mid-burst aborts immediately; no done pulse; partial symbol discarded.
- start accepted at cycle t → busy=1 at t+1; first slot (k=0 null) sc_valid=1 at t+2.
- Full throughput: one slot per cycle with sc_ready and data_valid held high. N_SC×num_symbols slots then take N_SC×num_symbols cycles from the first sc_valid.
- done asserts the cycle after the final handshake. busy drops in the same cycle. A new start is accepted the cycle after done.
- Data sample accepted at cycle t appears on sc_i/sc_q at t+1.

## Structure
- Shared package ofdm_pkg: W, N_SC defaults, slot-class enum {SLOT_NULL, SLOT_PILOT, SLOT_DATA}, state enum, sat_negate function.
- One sub-module ofdm_slot_classifier: combinational map from index to slot class. Everything else stays flat.

## Test plan
- Defaults, num_symbols=1, pilot=(0x0014,0x0028), data counts 1..55, sc_ready=1 → 64 slots; k=0 is (0,0); k=4,12..60 are (0x0014,0x0028); data in order; sc_last at k=63; done one cycle later.
- num_symbols=2 → symbol 1 pilots are (0xFFEC,0xFFD8); pilot_i=0x8000 on odd symbol → 0x7FFF.
- Random sc_ready and data_valid stalls → outputs stable while stalled; no sample loss or duplication; data_ready never high on null/pilot slots.
- start with num_symbols=0 → done at t+1, no sc_valid. start pulsed during RUN → ignored; burst length unchanged.
- rst asserted at slot 30 of symbol 0 → next cycle all outputs at reset values; no done. A fresh start runs a full correct burst.
